// File: rtl/fifo_rd_pair.sv
// Pops two consecutive half-words from a FIFO register file and presents them as one word (MSB first).
// Optional accepted-word counter on port word_cnt, enabled by defining FIFO_RD_PAIR_CNT_EN.
module fifo_rd_pair #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    empty,
    input  logic [DATA_WIDTH-1:0]   r_data,
    output logic                    rd,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef FIFO_RD_PAIR_CNT_EN
   ,output logic [15:0]             word_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   msb_q, msb_d;
    logic [2*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    // Reset is folded in so no pop is issued while the block is held in reset.
    always_comb begin
        rd = 1'b0;
        if (reset && !empty) begin
            case (state_q)
                IDLE:    rd = 1'b1;
                HALF:    rd = 1'b1;
                FULL:    rd = out_ready;
                default: rd = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        msb_d       = msb_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (rd) begin
                    msb_d   = r_data;
                    state_d = HALF;
                end
            end
            HALF: begin
                if (rd) begin
                    out_data_d  = {msb_q, r_data};
                    out_valid_d = 1'b1;
                    state_d     = FULL;
                end
            end
            FULL: begin
                // Consuming the word and popping the next MSB share the same cycle.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (rd) begin
                        msb_d   = r_data;
                        state_d = HALF;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            msb_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            msb_q       <= msb_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef FIFO_RD_PAIR_CNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (out_valid_q && out_ready) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_pair.sv
// Self-checking bench for fifo_rd_pair: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_fifo_rd_pair;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        empty = 1'b1;
    logic [7:0]  r_data = '0;
    logic        rd;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef FIFO_RD_PAIR_CNT_EN
    logic [15:0] word_cnt;
`endif

    fifo_rd_pair #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .empty     (empty),
        .r_data    (r_data),
        .rd        (rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FIFO_RD_PAIR_CNT_EN
       ,.word_cnt  (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: halves popped since the last consumed word, plus the last completed word.
    logic [7:0]  held[$];
    logic [15:0] m_word = '0;
    logic [15:0] m_cnt = '0;
    logic        m_rd;
    logic        s_rd;

    typedef struct {
        logic        e;
        logic        rdy;
        logic [7:0]  d;
        logic        exp_rd;
        logic        exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        held.delete();
        m_word = '0;
        m_cnt  = '0;
    endtask

    // Drive inputs, sample rd before the edge, clock once, advance the model, settle.
    task automatic step(input logic e, input logic rdy, input logic [7:0] d);
        empty = e; out_ready = rdy; r_data = d;
        #1;
        s_rd = rd;
        m_rd = reset && !e && (held.size() < 2 || rdy);
        @(posedge clk);
        if (held.size() == 2 && rdy) begin
            held.delete();
            m_cnt = m_cnt + 16'd1;
        end
        if (m_rd) held.push_back(d);
        if (held.size() == 2) m_word = {held[0], held[1]};
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rd"}, {31'd0, s_rd}, {31'd0, m_rd});
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, held.size() == 2});
        chk({tag, "_data"}, {16'd0, out_data}, {16'd0, m_word});
`ifdef FIFO_RD_PAIR_CNT_EN
        chk({tag, "_cnt"}, {16'd0, word_cnt}, {16'd0, m_cnt});
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset = 1'b0;
        empty = 1'b0;
        #1;
        chk("rst_rd", {31'd0, rd}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        model_reset();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        // Reset, then hold empty for five cycles.
        #2;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, $urandom_range(0, 1), 8'($urandom));
            chk("idle_rd", {31'd0, s_rd}, 32'd0);
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_data", {16'd0, out_data}, 32'd0);
        end

        // Vector table: continuous stream, then a stalled word, then drain.
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{1'b0, 1'b1, 8'(i + 1), 1'b1, (i % 2) == 1,
                             (i < 1) ? 16'h0000 : {8'(((i - 1) / 2) * 2 + 1), 8'(((i - 1) / 2) * 2 + 2)}});
        end
        vecs.push_back('{1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 16'h0708});
        vecs.push_back('{1'b0, 1'b0, 8'hAB, 1'b1, 1'b0, 16'h0708});
        vecs.push_back('{1'b0, 1'b0, 8'hCD, 1'b1, 1'b1, 16'hABCD});
        for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 1'b0, 8'hEE, 1'b0, 1'b1, 16'hABCD});
        vecs.push_back('{1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 16'hABCD});
        foreach (vecs[i]) begin
            step(vecs[i].e, vecs[i].rdy, vecs[i].d);
            chk($sformatf("vec%0d_rd", i), {31'd0, s_rd}, {31'd0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_data", i), {16'd0, out_data}, {16'd0, vecs[i].exp_data});
        end

        // MSB popped, FIFO runs dry for three cycles, then the LSB arrives.
        step(1'b0, 1'b0, 8'h12);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'hFF);
            chk("dry_rd", {31'd0, s_rd}, 32'd0);
            chk("dry_valid", {31'd0, out_valid}, 32'd0);
        end
        step(1'b0, 1'b0, 8'h34);
        chk("dry_word_valid", {31'd0, out_valid}, 32'd1);
        chk("dry_word_data", {16'd0, out_data}, 32'h1234);
        step(1'b1, 1'b1, 8'h00);

        // Reset while holding a half: the held 8'h55 must be discarded.
        step(1'b0, 1'b0, 8'h55);
        pulse_reset();
        step(1'b0, 1'b0, 8'h66);
        chk("rst_half_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b0, 8'h77);
        chk("rst_half_valid2", {31'd0, out_valid}, 32'd1);
        chk("rst_half_data", {16'd0, out_data}, 32'h6677);
        step(1'b1, 1'b1, 8'h00);

        // Randomized traffic against the reference model, with occasional resets.
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
